// File: rtl/turbo_pkg.sv
// Shared constants and types for the turbo RSC encoder pair.
// The optional TURBO_STATE_MON_EN build adds state-monitor ports on the top level.
package turbo_pkg;

    localparam int RSC_MEM  = 3;
    localparam int TAIL_LEN = RSC_MEM;

    // Tap masks over the state vector, bit i = s_i.
    localparam logic [RSC_MEM-1:0] G_FB  = 3'b110;
    localparam logic [RSC_MEM-1:0] G_PAR = 3'b101;

    typedef logic [RSC_MEM-1:0] rsc_state_t;

endpackage

// File: rtl/turbo_rsc_pair_if.sv
// Control strobes from the encode FSM and output streams to the formatter.
// Debug state and term_err signals exist only when TURBO_STATE_MON_EN is defined.
interface turbo_rsc_pair_if;
    import turbo_pkg::*;

    logic enable;
    logic trellis_enable;
    logic clr;
    logic data_in;
    logic data_in_int;

    logic sys_out;
    logic par1_out;
    logic par2_out;
    logic sys2_out;
    logic out_valid;
    logic out_tail;
    logic tail_done;

`ifdef TURBO_STATE_MON_EN
    rsc_state_t enc1_state;
    rsc_state_t enc2_state;
    logic       term_err;

    modport master (
        output enable, trellis_enable, clr, data_in, data_in_int,
        input  sys_out, par1_out, par2_out, sys2_out, out_valid, out_tail, tail_done,
        input  enc1_state, enc2_state, term_err
    );

    modport slave (
        input  enable, trellis_enable, clr, data_in, data_in_int,
        output sys_out, par1_out, par2_out, sys2_out, out_valid, out_tail, tail_done,
        output enc1_state, enc2_state, term_err
    );
`else
    modport master (
        output enable, trellis_enable, clr, data_in, data_in_int,
        input  sys_out, par1_out, par2_out, sys2_out, out_valid, out_tail, tail_done
    );

    modport slave (
        input  enable, trellis_enable, clr, data_in, data_in_int,
        output sys_out, par1_out, par2_out, sys2_out, out_valid, out_tail, tail_done
    );
`endif

endinterface

// File: rtl/turbo_rsc_pair_rsc_core.sv
// One constituent RSC encoder: feedback 1+D^2+D^3, parity 1+D+D^3.
// The state output port is present only when TURBO_STATE_MON_EN is defined.
module rsc_core
    import turbo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       u_i,
    input  logic       step_i,
    input  logic       tail_i,
    input  logic       clr_i,
    output logic       parity_o,
    output logic       tail_u_o
`ifdef TURBO_STATE_MON_EN
    ,
    output rsc_state_t state_o
`endif
);

    rsc_state_t state_q;
    rsc_state_t state_d;
    logic       u_eff;
    logic       fb;

    // Feeding back the feedback taps as input forces fb to 0 and flushes the trellis.
    assign tail_u_o = ^(state_q & G_FB);
    assign u_eff    = tail_i ? tail_u_o : u_i;
    assign fb       = u_eff ^ (^(state_q & G_FB));
    assign parity_o = fb ^ (^(state_q & G_PAR));

    always_comb begin
        state_d = state_q;
        if (step_i || tail_i) begin
            state_d = {state_q[RSC_MEM-2:0], fb};
        end else if (clr_i) begin
            state_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef TURBO_STATE_MON_EN
    assign state_o = state_q;
`endif

endmodule

// File: rtl/turbo_rsc_pair.sv
// Dual RSC encoder datapath with trellis termination and a registered output stage.
// Defining TURBO_STATE_MON_EN adds enc1_state/enc2_state debug outputs and sticky term_err.
module turbo_rsc_pair
    import turbo_pkg::*;
#(
    parameter int TAIL_LEN = turbo_pkg::TAIL_LEN
) (
    input  logic             clk,
    input  logic             reset_n,
    turbo_rsc_pair_if.slave  bus
);

    localparam int                CNT_W     = $clog2(TAIL_LEN + 1);
    localparam logic [CNT_W-1:0]  TAIL_MAX  = CNT_W'(TAIL_LEN);
    localparam logic [CNT_W-1:0]  TAIL_LAST = CNT_W'(TAIL_LEN - 1);

    logic [CNT_W-1:0] tail_cnt_q, tail_cnt_d;
    logic             tail_go, step_go, clr_go;
    logic             par1, par2, tail_u1, tail_u2;

    logic sys_q, sys_d;
    logic par1_q, par1_d;
    logic par2_q, par2_d;
    logic sys2_q, sys2_d;
    logic valid_q, valid_d;
    logic tail_q, tail_d;
    logic done_q, done_d;

    // Termination outranks encode; clr is dropped whenever either window is open.
    assign tail_go = bus.trellis_enable && (tail_cnt_q < TAIL_MAX);
    assign step_go = bus.enable && !bus.trellis_enable;
    assign clr_go  = bus.clr && !bus.enable && !bus.trellis_enable;

`ifdef TURBO_STATE_MON_EN
    rsc_state_t st1, st2;
    logic       term_err_q, term_err_d;
`endif

    rsc_core u_enc1 (
        .clk      (clk),
        .rst_n    (reset_n),
        .u_i      (bus.data_in),
        .step_i   (step_go),
        .tail_i   (tail_go),
        .clr_i    (clr_go),
        .parity_o (par1),
        .tail_u_o (tail_u1)
`ifdef TURBO_STATE_MON_EN
        ,
        .state_o  (st1)
`endif
    );

    rsc_core u_enc2 (
        .clk      (clk),
        .rst_n    (reset_n),
        .u_i      (bus.data_in_int),
        .step_i   (step_go),
        .tail_i   (tail_go),
        .clr_i    (clr_go),
        .parity_o (par2),
        .tail_u_o (tail_u2)
`ifdef TURBO_STATE_MON_EN
        ,
        .state_o  (st2)
`endif
    );

    always_comb begin
        tail_cnt_d = tail_cnt_q;
        sys_d      = 1'b0;
        par1_d     = 1'b0;
        par2_d     = 1'b0;
        sys2_d     = 1'b0;
        valid_d    = 1'b0;
        tail_d     = 1'b0;
        done_d     = 1'b0;

        if (!bus.trellis_enable) begin
            tail_cnt_d = '0;
        end else if (tail_go) begin
            tail_cnt_d = tail_cnt_q + 1'b1;
        end

        if (tail_go) begin
            sys_d   = tail_u1;
            par1_d  = par1;
            sys2_d  = tail_u2;
            par2_d  = par2;
            valid_d = 1'b1;
            tail_d  = 1'b1;
            done_d  = (tail_cnt_q == TAIL_LAST);
        end else if (step_go) begin
            sys_d   = bus.data_in;
            par1_d  = par1;
            par2_d  = par2;
            valid_d = 1'b1;
        end
    end

`ifdef TURBO_STATE_MON_EN
    // States are sampled on the cycle tail_done is visible, i.e. after the last tail step.
    assign term_err_d = term_err_q | (done_q & ((|st1) | (|st2)));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tail_cnt_q <= '0;
            sys_q      <= 1'b0;
            par1_q     <= 1'b0;
            par2_q     <= 1'b0;
            sys2_q     <= 1'b0;
            valid_q    <= 1'b0;
            tail_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TURBO_STATE_MON_EN
            term_err_q <= 1'b0;
`endif
        end else begin
            tail_cnt_q <= tail_cnt_d;
            sys_q      <= sys_d;
            par1_q     <= par1_d;
            par2_q     <= par2_d;
            sys2_q     <= sys2_d;
            valid_q    <= valid_d;
            tail_q     <= tail_d;
            done_q     <= done_d;
`ifdef TURBO_STATE_MON_EN
            term_err_q <= term_err_d;
`endif
        end
    end

    assign bus.sys_out   = sys_q;
    assign bus.par1_out  = par1_q;
    assign bus.par2_out  = par2_q;
    assign bus.sys2_out  = sys2_q;
    assign bus.out_valid = valid_q;
    assign bus.out_tail  = tail_q;
    assign bus.tail_done = done_q;

`ifdef TURBO_STATE_MON_EN
    assign bus.enc1_state = st1;
    assign bus.enc2_state = st2;
    assign bus.term_err   = term_err_q;
`endif

endmodule

// File: tb/tb_turbo_rsc_pair.sv
// Self-checking bench for turbo_rsc_pair using a sequence-level RSC reference model.
// Monitor-port checks are compiled in when TURBO_STATE_MON_EN is defined.
module tb_turbo_rsc_pair;
    import turbo_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    turbo_rsc_pair_if bus ();

    turbo_rsc_pair dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference: per encoder, the last three feedback values a[k-1], a[k-2], a[k-3].
    bit h [2][1:3];
    int mtail = 0;
    bit e_sys, e_p1, e_p2, e_sys2, e_v, e_t, e_d;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < 2; e++)
            for (int k = 1; k <= 3; k++) h[e][k] = 1'b0;
    endtask

    // a[k] = u ^ a[k-2] ^ a[k-3], parity = a[k] ^ a[k-1] ^ a[k-3]; tail input makes a[k] = 0.
    task automatic model_enc(input int e, input bit tail, input bit u_in,
                             output bit u_used, output bit par);
        bit a;
        u_used = tail ? (h[e][2] ^ h[e][3]) : u_in;
        a      = u_used ^ h[e][2] ^ h[e][3];
        par    = a ^ h[e][1] ^ h[e][3];
        h[e][3] = h[e][2];
        h[e][2] = h[e][1];
        h[e][1] = a;
    endtask

    task automatic model_cycle(input bit en, input bit te, input bit cl, input bit d, input bit di);
        bit u1, u2, p1, p2;
        {e_sys, e_p1, e_p2, e_sys2, e_v, e_t, e_d} = '0;
        if (te && mtail < TAIL_LEN) begin
            model_enc(0, 1'b1, 1'b0, u1, p1);
            model_enc(1, 1'b1, 1'b0, u2, p2);
            e_sys = u1; e_p1 = p1; e_sys2 = u2; e_p2 = p2;
            e_v = 1'b1; e_t = 1'b1;
            e_d = (mtail == TAIL_LEN - 1);
            mtail++;
        end else begin
            if (!te) mtail = 0;
            if (en && !te) begin
                model_enc(0, 1'b0, d, u1, p1);
                model_enc(1, 1'b0, di, u2, p2);
                e_sys = d; e_p1 = p1; e_p2 = p2; e_v = 1'b1;
            end else if (cl && !en && !te) begin
                model_clear();
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_sys"},   3'(bus.sys_out),   3'(e_sys));
        chk({tag, "_par1"},  3'(bus.par1_out),  3'(e_p1));
        chk({tag, "_par2"},  3'(bus.par2_out),  3'(e_p2));
        chk({tag, "_sys2"},  3'(bus.sys2_out),  3'(e_sys2));
        chk({tag, "_valid"}, 3'(bus.out_valid), 3'(e_v));
        chk({tag, "_tail"},  3'(bus.out_tail),  3'(e_t));
        chk({tag, "_done"},  3'(bus.tail_done), 3'(e_d));
`ifdef TURBO_STATE_MON_EN
        chk({tag, "_st1"}, bus.enc1_state, {h[0][3], h[0][2], h[0][1]});
        chk({tag, "_st2"}, bus.enc2_state, {h[1][3], h[1][2], h[1][1]});
`endif
    endtask

    task automatic cyc(input string tag, input bit en, input bit te, input bit cl,
                       input bit d, input bit di);
        bus.enable = en; bus.trellis_enable = te; bus.clr = cl;
        bus.data_in = d; bus.data_in_int = di;
        model_cycle(en, te, cl, d, di);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Called at posedge+1: reset asserts mid-cycle and outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        bus.enable = 1'b0; bus.trellis_enable = 1'b0; bus.clr = 1'b0;
        bus.data_in = 1'b0; bus.data_in_int = 1'b0;
        #1;
        model_clear();
        mtail = 0;
        {e_sys, e_p1, e_p2, e_sys2, e_v, e_t, e_d} = '0;
        check_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic impulse_block(input string tag);
        bit imp_par [4];
        imp_par = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            cyc(tag, 1'b1, 1'b0, 1'b0, (i == 0), 1'($urandom));
            chk({tag, "_imp_par1"}, 3'(bus.par1_out), 3'(imp_par[i]));
            chk({tag, "_imp_sys"},  3'(bus.sys_out),  3'(i == 0));
        end
    endtask

    task automatic impulse_tail(input string tag, input bit clr_first);
        bit t_sys [3];
        bit t_par [3];
        t_sys = '{1'b1, 1'b0, 1'b1};
        t_par = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cyc(tag, 1'b0, 1'b1, (clr_first && i == 0), 1'b0, 1'b0);
            chk({tag, "_tl_sys"},  3'(bus.sys_out),   3'(t_sys[i]));
            chk({tag, "_tl_par1"}, 3'(bus.par1_out),  3'(t_par[i]));
            chk({tag, "_tl_tail"}, 3'(bus.out_tail),  3'b001);
            chk({tag, "_tl_done"}, 3'(bus.tail_done), 3'(i == 2));
        end
    endtask

    initial begin
        int len, tl, idle;
        bus.enable = 1'b0; bus.trellis_enable = 1'b0; bus.clr = 1'b0;
        bus.data_in = 1'b0; bus.data_in_int = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) cyc("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        impulse_block("imp");
        impulse_tail("imp", 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc("imp_post", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("imp_post_valid", 3'(bus.out_valid), 3'b000);
        end
        cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        impulse_block("clrte");
        impulse_tail("clrte", 1'b1);
        cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        cyc("clridle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc("clridle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("clridle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("clridle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("clridle_par1_zero", 3'(bus.par1_out), 3'b000);
        chk("clridle_par2_zero", 3'(bus.par2_out), 3'b000);
        for (int i = 0; i < 3; i++) cyc("clridle_tl", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        impulse_block("rstmid");
        cyc("rstmid_t1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset("rstmid_async");
        impulse_block("rstmid_new");
        impulse_tail("rstmid_new", 1'b0);
        cyc("gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int b = 0; b < 12; b++) begin
            len = int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++)
                cyc("rnd_enc", 1'($urandom_range(0, 3) != 0), 1'b0, 1'($urandom_range(0, 5) == 0),
                    1'($urandom), 1'($urandom));
            idle = int'($urandom_range(0, 2));
            for (int k = 0; k < idle; k++)
                cyc("rnd_idle", 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            tl = int'($urandom_range(2, 5));
            for (int k = 0; k < tl; k++)
                cyc("rnd_tail", 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
            cyc("rnd_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

`ifdef TURBO_STATE_MON_EN
        impulse_block("mon");
        cyc("mon_short", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mon_short", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mon_short_nodone", 3'(bus.tail_done), 3'b000);
        cyc("mon_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("mon_retry", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mon_retry_done", 3'(bus.tail_done), 3'b001);
        cyc("mon_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("mon_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mon_term_ok", 3'(bus.term_err), 3'b000);

        impulse_block("flt");
        for (int i = 0; i < 3; i++) cyc("flt_tail", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.trellis_enable = 1'b0;
        force dut.u_enc1.state_q = 3'b010;
        @(posedge clk);
        #1;
        release dut.u_enc1.state_q;
        chk("flt_term_set", 3'(bus.term_err), 3'b001);
        @(posedge clk);
        #1;
        chk("flt_term_sticky", 3'(bus.term_err), 3'b001);
        async_reset("flt_rst");
        chk("flt_term_clr", 3'(bus.term_err), 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
